// File: rtl/wb_slave_arbiter.sv
// Round-robin arbiter that shares one Wishbone slave port between two requesters.
// Latency: a strobe sampled in IDLE is forwarded to the slave one cycle later.
// Backpressure: the granted requester stalls until the slave acks or the watchdog expires; the other requester waits.
//
// Ports: clk/rst_n; requester ports m0_*/m1_* (stb/we/adr/dat in, dat/ack/err out);
// slave port s_* (stb/we/adr/dat out, dat/ack in); arb_busy_o/arb_gnt_o status.
module wb_slave_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  output logic        arb_busy_o,
  output logic        arb_gnt_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, ERR = 2'd2} state_t;

  state_t      state, state_nxt;
  logic        gnt, gnt_nxt;
  logic        last_served, last_served_nxt;
  logic [7:0]  wdog, wdog_nxt;

  // Signals of whichever requester currently holds the grant.
  logic        g_stb, g_we, g_ack;
  logic [31:0] g_adr, g_dat, g_rdat;

  assign g_stb  = gnt ? m1_stb_i : m0_stb_i;
  assign g_we   = gnt ? m1_we_i  : m0_we_i;
  assign g_adr  = gnt ? m1_adr_i : m0_adr_i;
  assign g_dat  = gnt ? m1_dat_i : m0_dat_i;
  assign g_ack  = s_ack_i & g_stb;
  assign g_rdat = (g_ack & ~g_we) ? s_dat_i : 32'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      gnt         <= 1'b0;
      last_served <= 1'b1;  // makes requester 0 win the first tie
      wdog        <= 8'd0;
    end else begin
      state       <= state_nxt;
      gnt         <= gnt_nxt;
      last_served <= last_served_nxt;
      wdog        <= wdog_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    gnt_nxt         = gnt;
    last_served_nxt = last_served;
    wdog_nxt        = wdog;
    s_stb_o         = 1'b0;
    s_we_o          = 1'b0;
    s_adr_o         = 32'd0;
    s_dat_o         = 32'd0;
    m0_dat_o        = 32'd0;
    m0_ack_o        = 1'b0;
    m0_err_o        = 1'b0;
    m1_dat_o        = 32'd0;
    m1_ack_o        = 1'b0;
    m1_err_o        = 1'b0;
    arb_busy_o      = (state != IDLE);
    arb_gnt_o       = (state != IDLE) & gnt;

    case (state)
      IDLE: begin
        wdog_nxt = 8'd0;
        if (m0_stb_i && m1_stb_i) begin
          gnt_nxt   = ~last_served;
          state_nxt = BUSY;
        end else if (m0_stb_i) begin
          gnt_nxt   = 1'b0;
          state_nxt = BUSY;
        end else if (m1_stb_i) begin
          gnt_nxt   = 1'b1;
          state_nxt = BUSY;
        end
      end

      BUSY: begin
        s_stb_o = g_stb;
        s_we_o  = g_we;
        s_adr_o = g_adr;
        s_dat_o = g_we ? g_dat : 32'd0;
        if (gnt) begin
          m1_ack_o = g_ack;
          m1_dat_o = g_rdat;
        end else begin
          m0_ack_o = g_ack;
          m0_dat_o = g_rdat;
        end
        // Ack is checked before the watchdog so a late ack still completes.
        if (g_ack) begin
          last_served_nxt = gnt;
          state_nxt       = IDLE;
        end else if (!g_stb) begin
          state_nxt = IDLE;  // requester abandoned; fairness state untouched
        end else if (wdog == 8'(TIMEOUT - 1)) begin
          state_nxt = ERR;
        end else begin
          wdog_nxt = wdog + 8'd1;
        end
      end

      ERR: begin
        if (gnt) m1_err_o = 1'b1;
        else     m0_err_o = 1'b1;
        last_served_nxt = gnt;
        state_nxt       = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/wb_slave_arbiter.md
Name: wb_slave_arbiter

Overview:
- Two-requester arbiter that shares the single Wishbone slave port (FPU register/command space) between the AMBA slave wrapper (requester 0) and the FPU sequencer/DMA path (requester 1).
- Grants one requester at a time using round-robin priority.
- Forwards that requester's strobe, write, address and data to the slave, and routes the ack and read data back to it.
- Aborts a stalled transfer with an error pulse after a watchdog timeout.

Parameters:
- TIMEOUT, 16, number of BUSY cycles without s_ack_i before abort; legal range 2..255 (8-bit counter).

Ports:
- clk  input  1  system clock, all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- m0_stb_i  input  1  requester 0 strobe; held until m0_ack_o or m0_err_o.
- m0_we_i  input  1  requester 0 write enable.
- m0_adr_i  input  32  requester 0 address.
- m0_dat_i  input  32  requester 0 write data.
- m0_dat_o  output  32  read data to requester 0.
- m0_ack_o  output  1  transfer-complete to requester 0.
- m0_err_o  output  1  timeout abort to requester 0.
- m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i, m1_dat_o, m1_ack_o, m1_err_o  same widths/meaning for requester 1.
- s_stb_o  output  1  strobe to shared slave.
- s_we_o  output  1  write enable to slave.
- s_adr_o  output  32  address to slave.
- s_dat_o  output  32  write data to slave.
- s_dat_i  input  32  read data from slave.
- s_ack_i  input  1  slave acknowledge.
- arb_busy_o  output  1  high while state is BUSY or ERR.
- arb_gnt_o  output  1  registered grant index, valid while arb_busy_o is high.

Behaviour:
- Reset (async, rst_n low):
  - state IDLE, gnt = 0, last_served = 1, so requester 0 wins the first tie; wdog counter = 0.
  - All outputs 0 while in reset and in IDLE.
- States: IDLE, BUSY, ERR, held in a 2-bit state register.
- IDLE:
  - Only m0_stb_i high: gnt <= 0, go to BUSY.
  - Only m1_stb_i high: gnt <= 1, go to BUSY.
  - Both high: gnt <= ~last_served, go to BUSY.
  - Neither high: stay in IDLE.
  - wdog <= 0 on every IDLE cycle.
- Latency: a requester strobe sampled at edge N gives s_stb_o high in the cycle after edge N (1 cycle).
- BUSY, combinational forwarding from the granted requester gX:
  - s_stb_o = mX_stb_i, s_we_o = mX_we_i, s_adr_o = mX_adr_i.
  - s_dat_o = mX_dat_i when mX_we_i is high, else 0.
  - mX_ack_o = s_ack_i & mX_stb_i.
  - mX_dat_o = s_dat_i when s_ack_i & mX_stb_i & ~mX_we_i, else 0.
  - The non-granted requester sees ack = 0, err = 0, dat = 0.
- BUSY transitions:
  - s_ack_i & mX_stb_i: last_served <= gnt, go to IDLE.
  - mX_stb_i low (requester abandons): go to IDLE, last_served unchanged, no ack forwarded.
  - No ack and wdog == TIMEOUT-1: go to ERR.
  - Otherwise: wdog <= wdog + 1.
- ERR (exactly 1 cycle):
  - s_stb_o = 0; mX_err_o = 1 for the granted requester only.
  - last_served <= gnt, go to IDLE.
  - The requester drops its strobe on seeing err.
- IDLE always follows a completed transfer (one dead cycle). A requester whose strobe is still high in that IDLE cycle is treated as a new request.
- Round-robin: after a completion or error by requester X, a simultaneous request from both is granted to the other requester.
- Simultaneous events:
  - s_ack_i in the same cycle the wdog expires: ack wins, no ERR.
  - s_ack_i while the granted strobe is low: ignored, return to IDLE.
- Grant is never changed mid-transfer; requests from the non-granted requester wait with no timeout of their own.
- Reset asserted mid-transfer: s_stb_o and all acks/errs drop immediately; state returns to IDLE with last_served = 1.

Test Plan:
- Reset, m0 write adr=0x10, dat=0xDEADBEEF, slave acks in 3rd BUSY cycle -> s_stb_o/s_we_o=1, s_adr_o=0x10, s_dat_o=0xDEADBEEF for 3 cycles; m0_ack_o 1 cycle; m1 outputs 0; IDLE next.
- After reset, m0 and m1 both strobe continuously, slave acks every 1st BUSY cycle -> arb_gnt_o sequence 0,1,0,1 with one IDLE cycle between grants.
- m1 read adr=0x24, slave returns 0x3F800000 with ack -> m1_dat_o = 0x3F800000 in the ack cycle only; m0_dat_o = 0; m1_dat_o = 0 afterwards.
- TIMEOUT=16, m0 strobe, slave never acks -> s_stb_o high 16 cycles, then 1 cycle m0_err_o=1 with s_stb_o=0, then IDLE; next tie goes to m1.
- s_ack_i in the 16th BUSY cycle (the wdog expiry cycle) -> m0_ack_o=1, m0_err_o stays 0, no ERR state.
- m1 BUSY, rst_n low for 1 cycle mid-transfer -> all outputs 0 asynchronously; after release with both strobing, m0 is granted first.
